// File: rtl/trap_pkg.sv
// trap_pkg: state encoding, cause-code helper and default synchroniser depth
// shared by the trap controller files.
package trap_pkg;

  typedef enum logic {
    ST_UNTRAPPED = 1'b0,
    ST_TRAPPED   = 1'b1
  } trap_state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned WDOG_CNT_W          = 16;

  // The IRQ cause code sits directly above the highest maskable source index.
  function automatic int unsigned cause_irq(input int unsigned num_src);
    return num_src;
  endfunction

endpackage

// File: rtl/trap_ctrl_multi_if.sv
// trap_ctrl_multi_if: host-side CPU strobes, trap sources and trap status
// bundled between the Z80 glue logic (master) and the trap controller (slave).
interface trap_ctrl_multi_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CAUSE_W = 4
);

  logic               m1_n;
  logic               irq_sys_n;
  logic               irq_intercept;
  logic [NUM_SRC-1:0] src_event;
  logic [NUM_SRC-1:0] src_mask;
  logic               new_isr;
  logic               last_isr_untrap;
  logic               virtual_enabled;
  logic               cause_ack;
  logic               trap_state;
  logic               nmi_n;
  logic               capture_address;
  logic [NUM_SRC-1:0] pending;
  logic [CAUSE_W-1:0] cause;
  logic               cause_valid;
  logic               wdog_fault;

  modport master (
    output m1_n, irq_sys_n, irq_intercept, src_event, src_mask, new_isr,
           last_isr_untrap, virtual_enabled, cause_ack,
    input  trap_state, nmi_n, capture_address, pending, cause, cause_valid,
           wdog_fault
  );

  modport slave (
    input  m1_n, irq_sys_n, irq_intercept, src_event, src_mask, new_isr,
           last_isr_untrap, virtual_enabled, cause_ack,
    output trap_state, nmi_n, capture_address, pending, cause, cause_valid,
           wdog_fault
  );

endinterface

// File: rtl/trap_sync_edge.sv
// trap_sync_edge: W-bit multi-flop synchroniser with rise/fall pulses taken
// from the synchronised value against its one-clock-old copy.
module trap_sync_edge
  import trap_pkg::*;
#(
  parameter int unsigned W       = 1,
  parameter int unsigned STAGES  = DEFAULT_SYNC_STAGES,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;

  // Synchroniser chain plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= {W{RST_VAL}};
      prev <= {W{RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/trap_ctrl_multi.sv
// trap_ctrl_multi: clocked trap/mode controller for the Nabu Z80 host.
// Collects maskable trap sources and the intercepted system IRQ, raises NMI,
// enters/leaves the trapped (host ISR) context on M1 fetch edges, records the
// winning cause and strobes address capture for the MegaMapper ISR.
// Optional watchdog on trapped M1 cycles: define TRAP_WDOG_EN.
module trap_ctrl_multi
  import trap_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned CAUSE_W     = 4,
  parameter int unsigned WDOG_M1     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  trap_ctrl_multi_if.slave        bus
);

  localparam logic [CAUSE_W-1:0] CAUSE_IRQ = CAUSE_W'(cause_irq(NUM_SRC));

  logic               m1_q_unused, m1_rise, m1_fall;
  logic               irq_q, irq_rise_unused, irq_fall_unused;
  logic [NUM_SRC-1:0] src_q_unused, src_rise, src_fall_unused;

  trap_state_e        state_q, state_d;
  logic               trapped;
  logic [NUM_SRC-1:0] pending_q;
  logic               irq_sync_q;
  logic               nmi_n_q;
  logic               capture_latch_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               cause_valid_q;

  logic [NUM_SRC-1:0] pend_en, win_onehot, pend_set, pend_clr;
  logic [CAUSE_W-1:0] win_idx;
  logic               irq_pend, any_pend, capture_go;

  trap_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_m1 (
    .clk(clk), .rst(rst), .d(bus.m1_n),
    .q(m1_q_unused), .rise(m1_rise), .fall(m1_fall)
  );

  trap_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_irq (
    .clk(clk), .rst(rst), .d(bus.irq_sys_n),
    .q(irq_q), .rise(irq_rise_unused), .fall(irq_fall_unused)
  );

  trap_sync_edge #(.W(NUM_SRC), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_src (
    .clk(clk), .rst(rst), .d(bus.src_event),
    .q(src_q_unused), .rise(src_rise), .fall(src_fall_unused)
  );

  assign trapped  = (state_q == ST_TRAPPED);
  assign pend_en  = pending_q & bus.src_mask;
  assign irq_pend = bus.irq_intercept & ~irq_sync_q;
  assign any_pend = (|pend_en) | irq_pend;

  // Lowest-index enabled pending source wins; IRQ only when no source is enabled.
  always_comb begin
    win_onehot = pend_en & ~(pend_en - NUM_SRC'(1));
    win_idx    = CAUSE_IRQ;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pend_en[i]) win_idx = CAUSE_W'(i);
    end
  end

  // Trap FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_TRAPPED;
    else     state_q <= state_d;
  end

  // Trap FSM next state and capture decision; only moves on an M1 falling edge.
  always_comb begin
    state_d    = state_q;
    capture_go = 1'b0;
    if (m1_fall) begin
      case (state_q)
        ST_UNTRAPPED: begin
          if (!bus.virtual_enabled) begin
            state_d = ST_TRAPPED;
          end else if (any_pend && bus.new_isr) begin
            state_d    = ST_TRAPPED;
            capture_go = 1'b1;
          end
        end
        ST_TRAPPED: begin
          if (bus.last_isr_untrap && bus.virtual_enabled) state_d = ST_UNTRAPPED;
        end
      endcase
    end
  end

  // Pending set/clear terms: a new event beats the capture clear of the winner.
  always_comb begin
    pend_set = src_rise & bus.src_mask & {NUM_SRC{~trapped}};
    pend_clr = (src_rise & {NUM_SRC{trapped}}) | (capture_go ? win_onehot : '0);
  end

  // Sticky pending bits, IRQ sample on M1 rise and registered NMI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      irq_sync_q <= 1'b1;
      nmi_n_q    <= 1'b1;
    end else begin
      pending_q <= pend_set | (pending_q & ~pend_clr);
      if (m1_rise) irq_sync_q <= irq_q;
      nmi_n_q <= ~(any_pend & ~trapped);
    end
  end

  // Capture latch, cause code and cause_valid; a capture overrides cause_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture_latch_q <= 1'b0;
      cause_q         <= '0;
      cause_valid_q   <= 1'b0;
    end else begin
      if (capture_go)   capture_latch_q <= 1'b1;
      else if (m1_fall) capture_latch_q <= 1'b0;
      if (capture_go) begin
        cause_q       <= win_idx;
        cause_valid_q <= 1'b1;
      end else if (bus.cause_ack) begin
        cause_valid_q <= 1'b0;
      end
    end
  end

`ifdef TRAP_WDOG_EN
  localparam logic [WDOG_CNT_W-1:0] WDOG_LIM = WDOG_CNT_W'(WDOG_M1);

  logic [WDOG_CNT_W-1:0] wdog_cnt_q;
  logic                  wdog_fault_q;

  // Count trapped M1 fetches; saturate at the limit and flag a sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q   <= '0;
      wdog_fault_q <= 1'b0;
    end else if (m1_fall && trapped && (state_d == ST_UNTRAPPED)) begin
      wdog_cnt_q   <= '0;
      wdog_fault_q <= 1'b0;
    end else if (m1_fall && trapped && bus.virtual_enabled) begin
      if (wdog_cnt_q != WDOG_LIM) wdog_cnt_q <= wdog_cnt_q + WDOG_CNT_W'(1);
      if (wdog_cnt_q >= WDOG_LIM - WDOG_CNT_W'(1)) wdog_fault_q <= 1'b1;
    end
  end

  assign bus.wdog_fault = wdog_fault_q;
`else
  localparam int unsigned WDOG_M1_UNUSED = WDOG_M1;
  assign bus.wdog_fault = 1'b0;
`endif

  assign bus.trap_state      = trapped;
  assign bus.nmi_n           = nmi_n_q;
  assign bus.pending         = pending_q;
  assign bus.cause           = cause_q;
  assign bus.cause_valid     = cause_valid_q;
  assign bus.capture_address = capture_latch_q
                             | (bus.last_isr_untrap & trapped & bus.virtual_enabled);

endmodule

// File: doc/trap_ctrl_multi.md
Name: trap_ctrl_multi

Overview:
- Clocked, parametrised successor to the Nabu CPLD trap/mode logic.
- Tracks NUM_SRC maskable trap sources plus the intercepted system IRQ.
- Drives NMI to the host Z80 and decides trap entry/exit on M1 fetch edges.
- Reports which source caused the trap and generates the address-capture strobe for the MegaMapper ISR.

Parameters:
- NUM_SRC, 4, number of trap sources on src_event (I/O violation, mapper fault, etc.), 1..8.
- SYNC_STAGES, 2, synchroniser depth for m1_n, irq_sys_n and src_event, 2..3.
- CAUSE_W, 4, cause code width; must satisfy 2^CAUSE_W > NUM_SRC.
- WDOG_M1, 1024, watchdog limit in M1 cycles (optional feature only), 2..65535.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- m1_n  in  1  Z80 M1, async, active-low.
- irq_sys_n  in  1  system IRQ, async, active-low.
- irq_intercept  in  1  enable IRQ as a trap source.
- src_event  in  NUM_SRC  trap source strobes, async; rising edge is the event.
- src_mask  in  NUM_SRC  1 = source enabled.
- new_isr  in  1  current fetch is an ISR-eligible boundary.
- last_isr_untrap  in  1  last ISR instruction is the untrap jump.
- virtual_enabled  in  1  virtualisation on.
- cause_ack  in  1  single-clk pulse; clears cause_valid.
- trap_state  out  1  1 = trapped (host ISR context).
- nmi_n  out  1  NMI to CPU, active-low.
- capture_address  out  1  address capture enable.
- pending  out  NUM_SRC  sticky pending bits.
- cause  out  CAUSE_W  code of the captured source; irq = NUM_SRC.
- cause_valid  out  1  cause holds an unacknowledged value.
- wdog_fault  out  1  watchdog expired (constant 0 without the feature).

Behaviour:
- Reset values: trap_state=1, nmi_n=1, capture_address=0, pending=0, cause=0, cause_valid=0, wdog_fault=0, irq_sync=1. All internal flops are async-cleared by rst.
- Synchronisation:
  - m1_n, irq_sys_n and src_event each pass through SYNC_STAGES flops.
  - m1_fall and m1_rise are single-clk pulses from the synchronised m1_n.
  - src_rise[i] is the edge-detected synchronised src_event[i].
- irq_sync samples synchronised irq_sys_n on m1_rise only.
- irq_pend = irq_intercept & !irq_sync.
- pending[i] update on each clk:
  - src_rise[i] & src_mask[i] & !trap_state -> set.
  - src_rise[i] & trap_state -> clear (event during trap cancels it).
  - Captured winner -> clear at capture.
  - If set and capture-clear coincide, set wins.
- any_pend = |(pending & src_mask) | irq_pend.
- nmi_n = !(any_pend & !trap_state), registered. nmi_n goes low 1 clk after pending sets.
- State machine: two states, UNTRAPPED and TRAPPED. It advances only on an m1_fall clk.
  - UNTRAPPED, virtual_enabled=0 -> TRAPPED, no capture.
  - UNTRAPPED, virtual_enabled=1, any_pend & new_isr -> TRAPPED.
    - capture_latch is set.
    - cause is loaded with the lowest-index enabled pending source, or NUM_SRC if only irq_pend.
    - cause_valid is set.
  - TRAPPED, last_isr_untrap & virtual_enabled -> UNTRAPPED.
- capture_latch clears on the next m1_fall after it was set.
- capture_address = capture_latch | (last_isr_untrap & trap_state & virtual_enabled), combinational from registered terms.
- cause_ack clears cause_valid. If a capture lands in the same clk, the capture wins and cause_valid stays 1.
- If src_mask drops while a bit is pending, the bit is retained but excluded from any_pend.
- If rst asserts mid-trap, the block returns to TRAPPED with no pending bits. This matches the virtualisation-off default.

Optional Feature:
- Macro TRAP_WDOG_EN.
- When defined:
  - A 16-bit counter increments on each m1_fall while TRAPPED & virtual_enabled, and clears on entry to UNTRAPPED.
  - When the counter reaches WDOG_M1, wdog_fault sets sticky and the counter saturates.
  - wdog_fault is cleared only by rst or by a subsequent untrap.
- When undefined: no counter; wdog_fault tied 0.

Decomposition:
- Shared package trap_pkg:
  - State encoding constants (ST_UNTRAPPED, ST_TRAPPED).
  - CAUSE_IRQ offset definition (= NUM_SRC).
  - Default synchroniser depth.
- One sub-module, trap_sync_edge: an N-bit synchroniser with rise/fall pulse outputs. It is instantiated for m1_n, irq_sys_n and src_event.
- The priority encoder stays inline.

Test Plan:
- Reset then virtual_enabled=1 with no events -> trap_state=1 until an m1_fall with last_isr_untrap=1, then trap_state=0 and nmi_n=1.
- Untrapped, src_event[2] pulse, src_mask=4'b1111 -> pending=4'b0100, then nmi_n=0. Next m1_fall with new_isr=1 -> trap_state=1, cause=2, cause_valid=1, capture_address high for exactly one M1 cycle, pending=0.
- Simultaneous src_event[1] and src_event[3] -> cause=1, pending[3] still 1 after the trap. After untrap, nmi_n=0 again and the next trap gives cause=3.
- irq_intercept=1 with irq_sys_n held low across m1_rise, no sources pending -> trap with cause=4 (NUM_SRC=4).
- While TRAPPED, src_event[0] pulse -> pending[0] stays 0. cause_ack in the same clk as a new capture -> cause_valid=1.
- With TRAP_WDOG_EN and WDOG_M1=8: 8 M1 cycles trapped -> wdog_fault=1, held until untrap. Without the macro -> wdog_fault=0 throughout.
